// File: rtl/ptp_bridge_dbg_pkg.sv
// ---------------------------------------------------------------------------
// ptp_bridge_dbg_pkg
// Shared definitions for the PTP bridge RX debug-region response path:
//   tag_t              - which target a recorded host read went to
//   RSP_*              - Avalon-MM response codes returned to the host
//   MISS_DATA          - readdata returned for reads that hit no region
//   TIMEOUT_DATA_BASE  - readdata base for forced completions (tag in LSBs)
// ---------------------------------------------------------------------------
package ptp_bridge_dbg_pkg;

  typedef enum logic [1:0] {
    TAG_RX0  = 2'd0,
    TAG_RX1  = 2'd1,
    TAG_MISS = 2'd2
  } tag_t;

  localparam logic [1:0] RSP_OKAY        = 2'b00;
  localparam logic [1:0] RSP_SLVERR      = 2'b10;
  localparam logic [1:0] RSP_DECODEERROR = 2'b11;

  localparam logic [31:0] MISS_DATA         = 32'hBADA_DD00;
  localparam logic [31:0] TIMEOUT_DATA_BASE = 32'hDEAD_0000;

endpackage

// File: rtl/ptp_bridge_rx_avmm_rsp_chk_if.sv
// ---------------------------------------------------------------------------
// ptp_bridge_rx_avmm_rsp_chk_if
// Groups the read-side bus of the response checker.
//   host_read          - upstream avmm_read
//   rgn_read_c1[1:0]   - registered region read strobes (bit0 RX_0, bit1 RX_1)
//   rgn_readdata       - per-region readdata, {RX_1, RX_0}
//   rgn_readdatavalid  - per-region readdatavalid
//   avmm_readdata      - merged in-order readdata to the host
//   avmm_readdatavalid - merged readdatavalid (one pulse per completion)
//   avmm_response      - 00 OKAY, 10 SLVERR, 11 DECODEERROR
// master: drives requests and region responses; slave: the response checker.
// ---------------------------------------------------------------------------
interface ptp_bridge_rx_avmm_rsp_chk_if #(
  parameter int DATA_WIDTH = 32
);
  import ptp_bridge_dbg_pkg::*;

  logic                    host_read;
  logic [1:0]              rgn_read_c1;
  logic [2*DATA_WIDTH-1:0] rgn_readdata;
  logic [1:0]              rgn_readdatavalid;
  logic [DATA_WIDTH-1:0]   avmm_readdata;
  logic                    avmm_readdatavalid;
  logic [1:0]              avmm_response;

  modport master (
    output host_read, rgn_read_c1, rgn_readdata, rgn_readdatavalid,
    input  avmm_readdata, avmm_readdatavalid, avmm_response
  );

  modport slave (
    input  host_read, rgn_read_c1, rgn_readdata, rgn_readdatavalid,
    output avmm_readdata, avmm_readdatavalid, avmm_response
  );

endinterface

// File: rtl/ptp_bridge_rsp_tag_fifo.sv
// ---------------------------------------------------------------------------
// ptp_bridge_rsp_tag_fifo
// Synchronous FIFO of read tags in host issue order.
//   clk, rst_n   - clock, asynchronous active-low reset (clears contents)
//   push/push_tag- enqueue a tag (ignored when full)
//   pop          - dequeue the head (ignored when empty)
//   head         - tag at the FIFO head
//   count        - number of stored tags
//   full, empty  - occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ptp_bridge_rsp_tag_fifo
  import ptp_bridge_dbg_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  tag_t          push_tag,
  input  logic          pop,
  output tag_t          head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  tag_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= TAG_MISS;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ptp_bridge_rx_avmm_rsp_chk.sv
// ---------------------------------------------------------------------------
// ptp_bridge_rx_avmm_rsp_chk
// Records every host read toward the RX_0 / RX_1 debug regions (or missing
// both) in issue order and merges the region responses back into a single
// in-order Avalon-MM readdata stream. Misses get a DECODEERROR word.
//   clk, rst_n       - clock, asynchronous active-low reset
//   bus (slave)      - host_read / region strobes and responses / merged output
//   rsp_almost_full  - registered, count >= MAX_OUTSTANDING-1
//   clr_err          - clears sticky errors and timeout_count
//   err_unexpected   - sticky: response nobody was waiting for / hold overrun
//   err_overflow     - sticky: read recorded while the tag FIFO was full
//   timeout_count    - saturating count of forced completions
// Build option PTP_BRIDGE_RX_RSP_TIMEOUT_EN: adds a head timer that force-
// completes a silent region read with SLVERR and discards its late response.
// Without it timeout_count is 0 and a silent region stalls the stream.
// ---------------------------------------------------------------------------
module ptp_bridge_rx_avmm_rsp_chk
  import ptp_bridge_dbg_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ptp_bridge_rx_avmm_rsp_chk_if.slave  bus,
  output logic                         rsp_almost_full,
  input  logic                         clr_err,
  output logic                         err_unexpected,
  output logic                         err_overflow,
  output logic [7:0]                   timeout_count
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic                       host_read_d1;
  tag_t                       push_tag;
  tag_t                       head;
  logic [CW-1:0]              count;
  logic [CW-1:0]              cnt_nxt;
  logic                       full, empty;
  logic [1:0][DATA_WIDTH-1:0] rgn_data;
  logic [1:0][DATA_WIDTH-1:0] hold_d;
  logic [1:0]                 hold_v;
  logic [1:0]                 discard, rv, fwd, cap, drop;
  logic                       head_rgn, head_idx;
  logic                       pop_miss, pop_hold, pop_live, pop_to, pop;
  logic                       timer_hit, unexp, ovf;
  logic [DATA_WIDTH-1:0]      out_data;
  logic [1:0]                 out_rsp;

  assign rgn_data = bus.rgn_readdata;
  assign push_tag = bus.rgn_read_c1[0] ? TAG_RX0 :
                    bus.rgn_read_c1[1] ? TAG_RX1 : TAG_MISS;

  ptp_bridge_rsp_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (host_read_d1),
    .push_tag (push_tag),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

`ifdef PTP_BRIDGE_RX_RSP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [1:0] stale_upd(input logic [1:0] v, input logic inc,
                                           input logic dec);
    if (inc && !dec) return (v == 2'd3) ? v : v + 2'd1;
    if (dec && !inc) return v - 2'd1;
    return v;
  endfunction

  logic [TW-1:0]   timer;
  logic [1:0][1:0] stale;

  assign timer_hit = (timer == TW'(TIMEOUT_CYCLES - 1));
  // A region that was force-completed still owes late responses; eat them.
  assign discard[0] = bus.rgn_readdatavalid[0] && (stale[0] != 2'd0);
  assign discard[1] = bus.rgn_readdatavalid[1] && (stale[1] != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer         <= '0;
      stale         <= '0;
      timeout_count <= 8'd0;
    end else begin
      if (!head_rgn || pop) timer <= '0;
      else                  timer <= timer + TW'(1);
      for (int r = 0; r < 2; r++)
        stale[r] <= stale_upd(stale[r], pop_to && (head_idx == 1'(r)), discard[r]);
      if (clr_err)     timeout_count <= pop_to ? 8'd1 : 8'd0;
      else if (pop_to) timeout_count <= sat_inc8(timeout_count);
    end
  end
`else
  logic unused_timeout_cfg;

  assign timer_hit          = 1'b0;
  assign discard            = 2'b00;
  assign timeout_count      = 8'd0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0) ^ TIMEOUT_DATA_BASE[0] ^ RSP_SLVERR[0];
`endif

  always_comb begin
    head_rgn = !empty && (head != TAG_MISS);
    head_idx = head[0];
    rv       = bus.rgn_readdatavalid & ~discard;
    pop_miss = !empty && (head == TAG_MISS);
    // A held response is older than any live one for the same region.
    pop_hold = head_rgn && hold_v[head_idx];
    pop_live = head_rgn && !hold_v[head_idx] && rv[head_idx];
    pop_to   = head_rgn && !hold_v[head_idx] && !rv[head_idx] && timer_hit;
    pop      = pop_miss || pop_hold || pop_live || pop_to;
    unexp    = 1'b0;
    for (int r = 0; r < 2; r++) begin
      fwd[r]  = pop_live && (head_idx == 1'(r));
      // The hold slot is free if empty or being drained this cycle.
      cap[r]  = rv[r] && !fwd[r] &&
                (!hold_v[r] || (pop_hold && (head_idx == 1'(r))));
      drop[r] = rv[r] && !fwd[r] && !cap[r];
      unexp   = unexp || drop[r] || (rv[r] && empty);
    end
    ovf = host_read_d1 && full;
    unique case ({host_read_d1 && !full, pop})
      2'b10:   cnt_nxt = count + CW'(1);
      2'b01:   cnt_nxt = count - CW'(1);
      default: cnt_nxt = count;
    endcase
    out_data = '0;
    out_rsp  = RSP_OKAY;
    if (pop_miss) begin
      out_data = DATA_WIDTH'(MISS_DATA);
      out_rsp  = RSP_DECODEERROR;
    end else if (pop_hold) begin
      out_data = hold_d[head_idx];
    end else if (pop_live) begin
      out_data = rgn_data[head_idx];
`ifdef PTP_BRIDGE_RX_RSP_TIMEOUT_EN
    end else if (pop_to) begin
      out_data = DATA_WIDTH'(TIMEOUT_DATA_BASE | 32'(head));
      out_rsp  = RSP_SLVERR;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_read_d1           <= 1'b0;
      hold_v                 <= '0;
      hold_d                 <= '0;
      bus.avmm_readdata      <= '0;
      bus.avmm_readdatavalid <= 1'b0;
      bus.avmm_response      <= RSP_OKAY;
      rsp_almost_full        <= 1'b0;
      err_unexpected         <= 1'b0;
      err_overflow           <= 1'b0;
    end else begin
      host_read_d1 <= bus.host_read;
      for (int r = 0; r < 2; r++) begin
        if (cap[r]) begin
          hold_v[r] <= 1'b1;
          hold_d[r] <= rgn_data[r];
        end else if (pop_hold && (head_idx == 1'(r))) begin
          hold_v[r] <= 1'b0;
        end
      end
      bus.avmm_readdatavalid <= pop;
      if (pop) begin
        bus.avmm_readdata <= out_data;
        bus.avmm_response <= out_rsp;
      end
      rsp_almost_full <= (cnt_nxt >= CW'(MAX_OUTSTANDING - 1));
      err_unexpected  <= unexp || (err_unexpected && !clr_err);
      err_overflow    <= ovf || (err_overflow && !clr_err);
    end
  end

endmodule

// File: tb/tb_ptp_bridge_rx_avmm_rsp_chk.sv
// ---------------------------------------------------------------------------
// tb_ptp_bridge_rx_avmm_rsp_chk
// Directed bench for ptp_bridge_rx_avmm_rsp_chk. Inputs change 1 ns after the
// rising edge; registered outputs are sampled at that same point, so a value
// seen after edge n was produced by the inputs of the previous cycle.
// The timeout scenario is built only with PTP_BRIDGE_RX_RSP_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_ptp_bridge_rx_avmm_rsp_chk;
  import ptp_bridge_dbg_pkg::*;

  localparam int DW = 32;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_err;
  logic       rsp_almost_full;
  logic       err_unexpected;
  logic       err_overflow;
  logic [7:0] timeout_count;
  int         compared   = 0;
  int         mismatched = 0;

  ptp_bridge_rx_avmm_rsp_chk_if #(.DATA_WIDTH(DW)) ifc ();

  ptp_bridge_rx_avmm_rsp_chk #(
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (4),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (ifc),
    .rsp_almost_full (rsp_almost_full),
    .clr_err         (clr_err),
    .err_unexpected  (err_unexpected),
    .err_overflow    (err_overflow),
    .timeout_count   (timeout_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic hr, input logic [1:0] rc, input logic [1:0] rv,
                     input logic [31:0] d0, input logic [31:0] d1);
    ifc.host_read         = hr;
    ifc.rgn_read_c1       = rc;
    ifc.rgn_readdatavalid = rv;
    ifc.rgn_readdata      = {d1, d0};
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {valid, response, data}
  function automatic logic [34:0] outw();
    return {ifc.avmm_readdatavalid, ifc.avmm_response, ifc.avmm_readdata};
  endfunction

  initial begin
    int n;
    int nv;
    rst_n   = 1'b0;
    clr_err = 1'b0;
    drv(0, 2'b00, 2'b00, 0, 0);
    repeat (3) tick();
    chk("rst_out", 64'(outw()), 64'(35'h0));
    chk("rst_af", 64'(rsp_almost_full), 64'(0));
    chk("rst_err", 64'({err_unexpected, err_overflow}), 64'(0));
    chk("rst_tc", 64'(timeout_count), 64'(0));
    rst_n = 1'b1;
    tick();

    // In-order responses: RX0 then RX1, each one cycle after its input.
    drv(1, 2'b00, 2'b00, 0, 0); tick();
    drv(1, 2'b01, 2'b00, 0, 0); tick();
    drv(0, 2'b10, 2'b00, 0, 0); tick();
    chk("t1_idle", 64'(ifc.avmm_readdatavalid), 64'(0));
    drv(0, 2'b00, 2'b01, 32'h11, 0); tick();
    chk("t1_rx0", 64'(outw()), 64'({1'b1, RSP_OKAY, 32'h11}));
    drv(0, 2'b00, 2'b10, 0, 32'h22); tick();
    chk("t1_rx1", 64'(outw()), 64'({1'b1, RSP_OKAY, 32'h22}));
    drv(0, 2'b00, 2'b00, 0, 0); tick();
    chk("t1_pulse", 64'(ifc.avmm_readdatavalid), 64'(0));

    // Out-of-order: RX1 answers first and is held until RX0 completes.
    drv(1, 2'b00, 2'b00, 0, 0); tick();
    drv(1, 2'b01, 2'b00, 0, 0); tick();
    drv(0, 2'b10, 2'b00, 0, 0); tick();
    drv(0, 2'b00, 2'b10, 0, 32'h22); tick();
    chk("t2_wait0", 64'(ifc.avmm_readdatavalid), 64'(0));
    drv(0, 2'b00, 2'b00, 0, 0); tick();
    chk("t2_wait1", 64'(ifc.avmm_readdatavalid), 64'(0));
    drv(0, 2'b00, 2'b01, 32'h11, 0); tick();
    chk("t2_rx0", 64'(outw()), 64'({1'b1, RSP_OKAY, 32'h11}));
    drv(0, 2'b00, 2'b00, 0, 0); tick();
    chk("t2_rx1", 64'(outw()), 64'({1'b1, RSP_OKAY, 32'h22}));
    tick();
    chk("t2_pulse", 64'(ifc.avmm_readdatavalid), 64'(0));
    chk("t2_noerr", 64'({err_unexpected, err_overflow}), 64'(0));

    // Miss: no region strobe.
    drv(1, 2'b00, 2'b00, 0, 0); tick();
    drv(0, 2'b00, 2'b00, 0, 0); tick();
    chk("t3_early", 64'(ifc.avmm_readdatavalid), 64'(0));
    tick();
    chk("t3_miss", 64'(outw()), 64'({1'b1, RSP_DECODEERROR, 32'hBADA_DD00}));
    tick();
    chk("t3_pulse", 64'(ifc.avmm_readdatavalid), 64'(0));

    // Unexpected response with empty FIFO; set wins over a same-cycle clear.
    drv(0, 2'b00, 2'b01, 32'h55, 0); tick();
    chk("t4_unexp", 64'(err_unexpected), 64'(1));
    drv(0, 2'b00, 2'b01, 32'h56, 0); clr_err = 1'b1; tick();
    chk("t4_setwins", 64'(err_unexpected), 64'(1));
    drv(0, 2'b00, 2'b00, 0, 0); tick();
    chk("t4_clr", 64'(err_unexpected), 64'(0));
    chk("t4_novld", 64'(ifc.avmm_readdatavalid), 64'(0));
    clr_err = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

    // Five reads without responses: almost-full after third, overflow on fifth.
    drv(1, 2'b00, 2'b00, 0, 0); tick();
    drv(1, 2'b01, 2'b00, 0, 0); tick();
    drv(1, 2'b01, 2'b00, 0, 0); tick();
    chk("t5_af_lo", 64'(rsp_almost_full), 64'(0));
    drv(1, 2'b01, 2'b00, 0, 0); tick();
    chk("t5_af_hi", 64'(rsp_almost_full), 64'(1));
    drv(1, 2'b01, 2'b00, 0, 0); tick();
    chk("t5_ovf_lo", 64'(err_overflow), 64'(0));
    drv(0, 2'b01, 2'b00, 0, 0); tick();
    chk("t5_ovf_hi", 64'(err_overflow), 64'(1));
    drv(0, 2'b00, 2'b00, 0, 0); clr_err = 1'b1; tick();
    clr_err = 1'b0; tick();
    chk("t5_ovf_clr", 64'(err_overflow), 64'(0));
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

    // Reset with three outstanding reads drops them silently.
    drv(1, 2'b00, 2'b00, 0, 0); tick();
    drv(1, 2'b10, 2'b00, 0, 0); tick();
    drv(1, 2'b01, 2'b00, 0, 0); tick();
    drv(0, 2'b10, 2'b00, 0, 0); tick();
    drv(0, 2'b00, 2'b00, 0, 0);
    chk("t6_af_pre", 64'(rsp_almost_full), 64'(1));
    rst_n = 1'b0; tick();
    chk("t6_rst_af", 64'(rsp_almost_full), 64'(0));
    tick(); rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 2 * TO; i++) begin
      tick();
      if (ifc.avmm_readdatavalid) nv++;
    end
    chk("t6_novld", 64'(nv), 64'(0));
    drv(1, 2'b00, 2'b00, 0, 0); tick();
    drv(0, 2'b10, 2'b00, 0, 0); tick();
    drv(0, 2'b00, 2'b10, 0, 32'h33); tick();
    chk("t6_new", 64'(outw()), 64'({1'b1, RSP_OKAY, 32'h33}));
    drv(0, 2'b00, 2'b00, 0, 0); tick();

`ifdef PTP_BRIDGE_RX_RSP_TIMEOUT_EN
    // Silent RX0: forced completion after TO cycles at the head.
    drv(1, 2'b00, 2'b00, 0, 0); tick();
    drv(0, 2'b01, 2'b00, 0, 0); tick();
    drv(0, 2'b00, 2'b00, 0, 0);
    chk("t7_idle", 64'(ifc.avmm_readdatavalid), 64'(0));
    n = 2;
    while (!ifc.avmm_readdatavalid && n < 4 * TO) begin
      tick();
      n++;
    end
    chk("t7_cycle", 64'(n), 64'(TO + 2));
    chk("t7_data", 64'(outw()), 64'({1'b1, RSP_SLVERR, 32'hDEAD_0000}));
    chk("t7_tc", 64'(timeout_count), 64'(1));
    drv(0, 2'b00, 2'b01, 32'hAA, 0); tick();
    chk("t7_late_v", 64'(ifc.avmm_readdatavalid), 64'(0));
    chk("t7_late_e", 64'(err_unexpected), 64'(0));
    drv(1, 2'b00, 2'b00, 0, 0); tick();
    drv(0, 2'b01, 2'b00, 0, 0); tick();
    drv(0, 2'b00, 2'b01, 32'h77, 0); tick();
    chk("t7_after", 64'(outw()), 64'({1'b1, RSP_OKAY, 32'h77}));
    drv(0, 2'b00, 2'b00, 0, 0); tick();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("t7_tc_clr", 64'(timeout_count), 64'(0));
`else
    chk("t7_tc_zero", 64'(timeout_count), 64'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ptp_bridge_rx_avmm_rsp_chk.md
# ptp_bridge_rx_avmm_rsp_chk

Response-side companion to the RX debug-region address checkers in the PTP bridge debug path. It records every host read issued toward the RX_0 / RX_1 debug regions, or missing both, in issue order. It merges the two regions' read responses back into one in-order Avalon-MM readdata stream for the host. Miss and timed-out reads are answered with a coded error word, so the host never hangs.

## Interface
- DATA_WIDTH, 32, readdata width
- MAX_OUTSTANDING, 4, tag FIFO depth; power of 2, ≥2
- TIMEOUT_CYCLES, 256, cycles a region read may sit at FIFO head before forced completion; ≥2
- clk  in  1  block clock
- rst_n  in  1  asynchronous, active-low reset
- host_read  in  1  upstream avmm_read, same cycle the address checkers sample it
- rgn_read_c1  in  2  registered read strobes from the checkers; bit0 = RX_0, bit1 = RX_1; at most one set
- rgn_readdata  in  2×DATA_WIDTH  per-region readdata
- rgn_readdatavalid  in  2  per-region readdatavalid
- avmm_readdata  out  DATA_WIDTH  merged host readdata
- avmm_readdatavalid  out  1  merged host readdatavalid
- avmm_response  out  2  00 OKAY, 10 SLVERR (timeout), 11 DECODEERROR (miss)
- rsp_almost_full  out  1  registered; high when count ≥ MAX_OUTSTANDING-1; upstream stalls reads on it
- clr_err  in  1  clears sticky error bits
- err_unexpected, err_overflow  out  1 each  sticky error flags
- timeout_count  out  8  saturating count of forced completions

## Operation
- Stage: host_read_d1 is host_read delayed one cycle, aligned with rgn_read_c1.
- Push tag when host_read_d1: RX0 if rgn_read_c1[0], RX1 if rgn_read_c1[1], else MISS.
- Push when count == MAX_OUTSTANDING: entry dropped, err_overflow set.
- Per region, a one-entry hold register (data + valid).
- A region rgn_readdatavalid is handled in this priority order:
  1. If the region's stale count is >0 (timeout build only), discard the response and decrement the stale count.
  2. If the head tag matches the region, forward the response and pop.
  3. If the hold register is empty, capture the response in it.
  4. If the hold register is full, drop the response and set err_unexpected.
- A response from a region with an empty FIFO and no stale count also sets err_unexpected.
- Head service, at most one pop per cycle:
  - Head is MISS: output 32'hBADA_DD00, response 11.
  - Head is RX0/RX1 and that region's hold is valid: output hold data, response 00, clear hold.
  - Head is RX0/RX1 with a live readdatavalid in the same cycle: output it, response 00.
- Simultaneous push and pop is allowed; count is unchanged.
- Both regions valid in the same cycle: the head's region is forwarded; the other goes to its hold register.
- clr_err clears err_unexpected, err_overflow and timeout_count. A same-cycle error set wins over the clear.

## Timing
- Every output registered; reset values: avmm_readdata 0, avmm_readdatavalid 0, avmm_response 00, rsp_almost_full 0, err_* 0, timeout_count 0. FIFO, hold registers, stale counts and timer are all cleared.
- Latency: live response at head → avmm_readdatavalid next cycle. Held response or MISS becoming head → output next cycle.
- avmm_readdatavalid is a single-cycle pulse per pop. Back-to-back pops are allowed every cycle.
- Reset mid-operation drops all outstanding entries; no response is emitted for them.

## Configuration
- PTP_BRIDGE_RX_RSP_TIMEOUT_EN defined:
  - The head timer counts while the head is RX0/RX1 and does not pop; it resets on every pop.
  - At TIMEOUT_CYCLES-1 the head pops with data 32'hDEAD_000{tag} and response 10.
  - The region's 2-bit saturating stale count increments; timeout_count increments, saturating at 255.
- Undefined: timer, stale counts and timeout output logic are absent. timeout_count is tied to 0, and a silent region stalls the stream indefinitely.

## Structure
- Shared package ptp_bridge_dbg_pkg holds:
  - tag typedef {TAG_RX0, TAG_RX1, TAG_MISS}
  - response code constants
  - MISS_DATA and TIMEOUT_DATA_BASE constants
- Sub-module ptp_bridge_rsp_tag_fifo: a synchronous tag FIFO with count, full and empty, reset by the same rst_n.

## Test plan
- Reads to RX0 then RX1; RX0 responds 0x11 at cycle 3, RX1 responds 0x22 at cycle 4 → outputs 0x11 then 0x22, response 00, each one cycle after its input.
- Reads RX0, RX1; RX1 responds 0x22 first, RX0 responds 0x11 two cycles later → 0x11 then 0x22 on consecutive cycles.
- host_read with no region strobe → 0xBADADD00, response 11, two cycles after host_read.
- Five reads issued with no responses (MAX_OUTSTANDING=4) → rsp_almost_full high after the third push; the fifth push sets err_overflow.
- Timeout build, RX0 silent → pop at cycle TIMEOUT_CYCLES with 0xDEAD0000, response 10, timeout_count=1. A late RX0 response is discarded with no error.
- rst_n asserted with 3 outstanding reads, then released → no readdatavalid; a new read completes normally.
